relay_sequencer: RTL
====================

Name: relay_sequencer

Overview:
- Downstream of the AUX_INPUT mode detector. Consumes its mode-decision strobe and drives the two relay coils.
- Enforces break-before-make dead time between relays and a minimum on-time before a relay may be switched again.
- Guarantees both coils are never energised together, drives the status LEDs, and provides a forced-off override.

Parameters:
- CNT_W, 26, width of the internal dwell counter.
- DEAD_CYCLES, 500000, cycles with both coils off between any de-energise and the next energise (10 ms at 50 MHz).
- HOLD_CYCLES, 2500000, minimum cycles a coil stays on before a new request is acted on (50 ms).
- CONFIRM_COUNT, 3, consecutive identical strobes required; used only with RELAY_CONFIRM_EN.

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MODE_VALID  in  1  one-cycle strobe from the mode detector.
- MODE_SEL  in  2  requested mode, sampled with MODE_VALID: 0=off, 1=relay A, 2=relay B, 3=reserved.
- FORCE_OFF  in  1  level; while high, both coils are off.
- RELAY_A  out  1  coil drive A.
- RELAY_B  out  1  coil drive B.
- ACTIVE_MODE  out  2  mode currently energised (0/1/2).
- BUSY  out  1  high in DEAD or ON_HOLD.
- REJECT  out  1  one-cycle pulse when a strobe is discarded as illegal.
- LED_OUTPUT  out  4  [0]=RELAY_A, [1]=RELAY_B, [2]=BUSY, [3]=pending-valid.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0.
  - State OFF, counter 0, pending cleared.
- Pending register, one deep:
  - Any MODE_VALID with MODE_SEL 0..2 while FORCE_OFF=0 writes pending and sets pending-valid on the next edge.
  - A newer strobe overwrites an older one.
  - MODE_SEL=3, or any strobe while FORCE_OFF=1, produces REJECT=1 for exactly one cycle and changes nothing else.
- If the strobe lands in the same cycle the FSM consumes pending, the new strobe is retained as pending-valid.
- FSM states:
  - OFF: both coils 0. Pending nonzero → ON_HOLD and energise the target (coil rises 2 cycles after the strobe). Pending 0 → drop it, stay in OFF.
  - ON_HOLD: target coil 1, counter counts to HOLD_CYCLES, then → ON_STABLE. Pending is kept but not acted on.
  - ON_STABLE: pending equal to ACTIVE_MODE → drop it. Pending different → both coils 0 on the next edge, → DEAD, pending retained.
  - DEAD: both coils 0, counter counts DEAD_CYCLES. On expiry:
    - pending target nonzero → ON_HOLD with that target (coil rises exactly DEAD_CYCLES cycles after the drop);
    - pending target 0, or nothing pending → OFF.
- ACTIVE_MODE follows the energised coil; it is 0 in OFF and DEAD.
- Counter: clears on every state entry and saturates at its terminal value; no wrap-around.
- FORCE_OFF (highest priority, any state):
  - Coils 0 on the next edge; pending cleared; → DEAD.
  - DEAD does not expire while FORCE_OFF is high, and its counter restarts when FORCE_OFF falls.
  - A full DEAD_CYCLES therefore always precedes any re-energise.
- Invariant: RELAY_A & RELAY_B is never 1 on any cycle. The coil change is break-only on one edge, make-only DEAD_CYCLES later.
- All outputs are registered.

Optional Feature:
- Macro RELAY_CONFIRM_EN.
- Defined:
  - A request becomes pending only after CONFIRM_COUNT consecutive legal strobes with identical MODE_SEL.
  - A differing legal strobe restarts the count at 1 with the new value.
  - REJECT strobes and FORCE_OFF reset the count to 0.
  - Latency is counted from the confirming strobe.
- Undefined: a single legal strobe sets pending; CONFIRM_COUNT is ignored.

Test Plan (DEAD_CYCLES=10, HOLD_CYCLES=20, confirm off unless stated):
- Reset, then strobe MODE_SEL=1 at cycle t → RELAY_A=1 at t+2; BUSY=1 for 20 cycles; ACTIVE_MODE=1; LED_OUTPUT=4'b0101 during hold.
- In ON_STABLE with A on, strobe 2 → RELAY_A=0 next edge, both 0 for exactly 10 cycles, then RELAY_B=1; A&B never both high.
- During ON_HOLD of A, strobe 2 then strobe 0 → pending=0, LED_OUTPUT[3]=1; after hold, A drops and the FSM returns to OFF after 10 dead cycles; B never rises.
- Strobe MODE_SEL=3 → REJECT single-cycle pulse, no state or coil change. Raise FORCE_OFF while B on, then strobe 1 → B=0 next edge, REJECT=1. Release FORCE_OFF → both coils stay 0 (OFF, pending cleared).
- Assert RESET_N low mid-DEAD → all outputs 0 immediately (async), state OFF after release.
- RELAY_CONFIRM_EN with CONFIRM_COUNT=3: strobe pattern 1,1,2,2,2 → no action after the first two; B energises 2 cycles after the fifth strobe.

Source files
------------

// File: rtl/relay_sequencer_if.sv
// relay_sequencer_if: mode-request inputs and coil/status outputs of the relay
// sequencer. The master side is the mode detector / supervisor, the slave side
// is the sequencer itself.
interface relay_sequencer_if;
    logic       MODE_VALID;
    logic [1:0] MODE_SEL;
    logic       FORCE_OFF;
    logic       RELAY_A;
    logic       RELAY_B;
    logic [1:0] ACTIVE_MODE;
    logic       BUSY;
    logic       REJECT;
    logic [3:0] LED_OUTPUT;

    modport master (
        output MODE_VALID, MODE_SEL, FORCE_OFF,
        input  RELAY_A, RELAY_B, ACTIVE_MODE, BUSY, REJECT, LED_OUTPUT
    );

    modport slave (
        input  MODE_VALID, MODE_SEL, FORCE_OFF,
        output RELAY_A, RELAY_B, ACTIVE_MODE, BUSY, REJECT, LED_OUTPUT
    );
endinterface

// File: rtl/relay_sequencer.sv
// relay_sequencer: turns mode-decision strobes into break-before-make drive of
// two relay coils, with a minimum on-time, a dead time between coils and a
// forced-off override. Both coils are never energised together.
// Optional build macro RELAY_CONFIRM_EN: a request only becomes pending after
// CONFIRM_COUNT consecutive identical legal strobes.
module relay_sequencer #(
    parameter int CNT_W         = 26,
    parameter int DEAD_CYCLES   = 500000,
    parameter int HOLD_CYCLES   = 2500000,
    parameter int CONFIRM_COUNT = 3
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    relay_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_ON_HOLD   = 2'd1,
        ST_ON_STABLE = 2'd2,
        ST_DEAD      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    if (CONFIRM_COUNT < 1) begin : g_confirm_range_check
        $error("CONFIRM_COUNT must be at least 1");
    end

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]       target_s;
    logic             consume_s;
    logic             legal_s, reject_s, accept_s;
    logic             pend_valid_r, pend_valid_nxt_s;
    logic [1:0]       pend_mode_r, pend_mode_nxt_s;
    logic             relay_a_r, relay_b_r, busy_r, reject_r;
    logic [1:0]       active_mode_r;
    logic [3:0]       led_r;
    logic             relay_a_nxt_s, relay_b_nxt_s, busy_nxt_s;
    logic [3:0]       led_nxt_s;

    assign legal_s  = bus.MODE_VALID & ~bus.FORCE_OFF & (bus.MODE_SEL != 2'd3);
    assign reject_s = bus.MODE_VALID & (bus.FORCE_OFF | (bus.MODE_SEL == 2'd3));

`ifdef RELAY_CONFIRM_EN
    logic [7:0] conf_cnt_r, conf_cnt_nxt_s;
    logic [1:0] conf_sel_r, conf_sel_nxt_s;

    // Confirmation counter: count consecutive identical legal strobes
    always_comb begin
        conf_cnt_nxt_s = conf_cnt_r;
        conf_sel_nxt_s = conf_sel_r;
        accept_s       = 1'b0;
        if (bus.FORCE_OFF || reject_s) begin
            conf_cnt_nxt_s = 8'd0;
        end else if (legal_s) begin
            if ((conf_cnt_r != 8'd0) && (bus.MODE_SEL == conf_sel_r)) begin
                conf_cnt_nxt_s = conf_cnt_r + 8'd1;
            end else begin
                conf_cnt_nxt_s = 8'd1;
            end
            conf_sel_nxt_s = bus.MODE_SEL;
            if (conf_cnt_nxt_s >= 8'(CONFIRM_COUNT)) begin
                accept_s       = 1'b1;
                conf_cnt_nxt_s = 8'd0;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            conf_cnt_nxt_s = conf_cnt_r;
        end
    end

    // Confirmation counter registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            conf_cnt_r <= 8'd0;
            conf_sel_r <= 2'd0;
        end else begin
            conf_cnt_r <= conf_cnt_nxt_s;
            conf_sel_r <= conf_sel_nxt_s;
        end
    end
`else
    assign accept_s = legal_s;
`endif

    // Next state: dwell timing, pending consumption and coil target selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        target_s    = active_mode_r;
        consume_s   = 1'b0;
        if (bus.FORCE_OFF) begin
            // Held in DEAD with the counter pinned so the full dead time restarts on release
            state_nxt_s = ST_DEAD;
            cnt_nxt_s   = {CNT_W{1'b0}};
            target_s    = 2'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    target_s = 2'd0;
                    if (pend_valid_r) begin
                        consume_s = 1'b1;
                        if (pend_mode_r != 2'd0) begin
                            state_nxt_s = ST_ON_HOLD;
                            cnt_nxt_s   = {CNT_W{1'b0}};
                            target_s    = pend_mode_r;
                        end else begin
                            state_nxt_s = ST_OFF;
                        end
                    end else begin
                        state_nxt_s = ST_OFF;
                    end
                end
                ST_ON_HOLD: begin
                    if (cnt_r >= HOLD_LAST) begin
                        state_nxt_s = ST_ON_STABLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ON_STABLE: begin
                    if (pend_valid_r) begin
                        if (pend_mode_r == active_mode_r) begin
                            consume_s = 1'b1;
                        end else begin
                            // Break only; the pending target is made after the dead time
                            state_nxt_s = ST_DEAD;
                            cnt_nxt_s   = {CNT_W{1'b0}};
                            target_s    = 2'd0;
                        end
                    end else begin
                        state_nxt_s = ST_ON_STABLE;
                    end
                end
                ST_DEAD: begin
                    target_s = 2'd0;
                    if (cnt_r >= DEAD_LAST) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                        consume_s = pend_valid_r;
                        if (pend_valid_r && (pend_mode_r != 2'd0)) begin
                            state_nxt_s = ST_ON_HOLD;
                            target_s    = pend_mode_r;
                        end else begin
                            state_nxt_s = ST_OFF;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = ST_DEAD;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    target_s    = 2'd0;
                end
            endcase
        end
    end

    // Pending request: a new accepted strobe wins over consumption in the same cycle
    always_comb begin
        pend_valid_nxt_s = pend_valid_r;
        pend_mode_nxt_s  = pend_mode_r;
        if (bus.FORCE_OFF) begin
            pend_valid_nxt_s = 1'b0;
            pend_mode_nxt_s  = 2'd0;
        end else if (accept_s) begin
            pend_valid_nxt_s = 1'b1;
            pend_mode_nxt_s  = bus.MODE_SEL;
        end else if (consume_s) begin
            pend_valid_nxt_s = 1'b0;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        relay_a_nxt_s = (target_s == 2'd1);
        relay_b_nxt_s = (target_s == 2'd2);
        busy_nxt_s    = (state_nxt_s == ST_ON_HOLD) || (state_nxt_s == ST_DEAD);
        led_nxt_s     = {pend_valid_nxt_s, busy_nxt_s, relay_b_nxt_s, relay_a_nxt_s};
    end

    // State, dwell counter and pending registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_OFF;
            cnt_r        <= {CNT_W{1'b0}};
            pend_valid_r <= 1'b0;
            pend_mode_r  <= 2'd0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_mode_r  <= pend_mode_nxt_s;
        end
    end

    // Registered coil, status and LED outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            relay_a_r     <= 1'b0;
            relay_b_r     <= 1'b0;
            active_mode_r <= 2'd0;
            busy_r        <= 1'b0;
            reject_r      <= 1'b0;
            led_r         <= 4'd0;
        end else begin
            relay_a_r     <= relay_a_nxt_s;
            relay_b_r     <= relay_b_nxt_s;
            active_mode_r <= target_s;
            busy_r        <= busy_nxt_s;
            reject_r      <= reject_s;
            led_r         <= led_nxt_s;
        end
    end

    assign bus.RELAY_A     = relay_a_r;
    assign bus.RELAY_B     = relay_b_r;
    assign bus.ACTIVE_MODE = active_mode_r;
    assign bus.BUSY        = busy_r;
    assign bus.REJECT      = reject_r;
    assign bus.LED_OUTPUT  = led_r;

endmodule
